// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 single-precision divider: restoring radix-2, one quotient bit per clock.
// Shares rounding-mode encoding and overflow/NaN policy with the fmul unit.
`timescale 1ns/1ps
module fdiv_seq #(
    parameter int QBITS = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic        busy,
    output logic        ready,
    output logic [31:0] s,
    output logic        dz
);

    localparam int CW = $clog2(QBITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PREP  = 2'd1,
        ST_DIV   = 2'd2,
        ST_ROUND = 2'd3
    } state_t;

    // Leading-zero count of a 24-bit mantissa (24 when zero).
    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            n = m[i] ? 5'(23 - i) : n;
        end
        return n;
    endfunction

    state_t            state_r, state_nx_s;
    logic [31:0]       a_r, b_r;
    logic [1:0]        rm_r;
    logic [CW-1:0]     cnt_r;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [23:0]       mb_r;
    logic [25:0]       rem_r;
    logic [QBITS-1:0]  quo_r;
    logic              spec_r, spec_dz_r;
    logic [31:0]       spec_val_r;
    logic              busy_r, ready_r, dz_r;
    logic [31:0]       s_r;

    // operand classification and normalisation (PREP)
    logic [7:0]        ea_s, eb_s, ea_max_s, eb_max_s;
    logic [22:0]       fa_s, fb_s;
    logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, sign_s;
    logic [23:0]       ma_s, mb_s, ma_n_s, mb_n_s;
    logic [4:0]        lza_s, lzb_s;
    logic signed [9:0] ea_eff_s, eb_eff_s, exp_prep_s;

    assign ea_s     = a_r[30:23];
    assign eb_s     = b_r[30:23];
    assign fa_s     = a_r[22:0];
    assign fb_s     = b_r[22:0];
    assign sign_s   = a_r[31] ^ b_r[31];
    assign a_zero_s = (ea_s == 8'd0)   && (fa_s == 23'd0);
    assign b_zero_s = (eb_s == 8'd0)   && (fb_s == 23'd0);
    assign a_inf_s  = (ea_s == 8'hff)  && (fa_s == 23'd0);
    assign b_inf_s  = (eb_s == 8'hff)  && (fb_s == 23'd0);
    assign a_nan_s  = (ea_s == 8'hff)  && (fa_s != 23'd0);
    assign b_nan_s  = (eb_s == 8'hff)  && (fb_s != 23'd0);
    assign ma_s     = {ea_s != 8'd0, fa_s};
    assign mb_s     = {eb_s != 8'd0, fb_s};
    assign lza_s    = lzc24(ma_s);
    assign lzb_s    = lzc24(mb_s);
    assign ma_n_s   = ma_s << lza_s;
    assign mb_n_s   = mb_s << lzb_s;
    assign ea_max_s = (ea_s == 8'd0) ? 8'd1 : ea_s;
    assign eb_max_s = (eb_s == 8'd0) ? 8'd1 : eb_s;
    assign ea_eff_s = $signed({2'b00, ea_max_s}) - $signed({5'b00000, lza_s});
    assign eb_eff_s = $signed({2'b00, eb_max_s}) - $signed({5'b00000, lzb_s});
    assign exp_prep_s = ea_eff_s - eb_eff_s + 10'sd127;

    logic        spec_s, spec_dz_s;
    logic [31:0] spec_val_s;
    logic [21:0] nan_frac_s;

    // special-operand result, overriding the datapath when set
    always_comb begin
        spec_s     = 1'b1;
        spec_dz_s  = 1'b0;
        spec_val_s = 32'd0;
        if (a_nan_s && (!b_nan_s || (fa_s >= fb_s))) begin
            nan_frac_s = fa_s[21:0];
        end else begin
            nan_frac_s = fb_s[21:0];
        end
        if (a_nan_s || b_nan_s) begin
            spec_val_s = {sign_s, 8'hff, 1'b1, nan_frac_s};
        end else if ((a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
            spec_val_s = {sign_s, 31'h7fc0_0000};
        end else if (a_inf_s) begin
            spec_val_s = {sign_s, 8'hff, 23'd0};
        end else if (b_zero_s) begin
            spec_val_s = {sign_s, 8'hff, 23'd0};
            spec_dz_s  = 1'b1;
        end else if (a_zero_s || b_inf_s) begin
            spec_val_s = {sign_s, 31'd0};
        end else begin
            spec_s     = 1'b0;
            spec_val_s = 32'd0;
        end
    end

    // one restoring step: trial subtract, keep on non-negative
    logic [26:0] diff_s;
    logic [25:0] rem_nx_s;
    logic        qbit_s;

    always_comb begin
        diff_s = {1'b0, rem_r} - {3'b000, mb_r};
        if (diff_s[26]) begin
            rem_nx_s = rem_r << 1;
            qbit_s   = 1'b0;
        end else begin
            rem_nx_s = diff_s[25:0] << 1;
            qbit_s   = 1'b1;
        end
    end

    logic [QBITS-1:0]  qn_s;
    logic signed [9:0] e1_s, e2_s, sh_s, expo_s;
    logic [25:0]       x_s, x2_s;
    logic              st_s, st2_s, inc_s, ovf_s;
    logic [4:0]        sh5_s;
    logic [57:0]       wide_s;
    logic [24:0]       m25_s;
    logic [22:0]       frac_s;
    logic [31:0]       res_s;

    // normalise quotient, denormalise, round and pack (ROUND)
    always_comb begin
        if (quo_r[QBITS-1]) begin
            qn_s = quo_r;
            e1_s = exp_r;
        end else begin
            qn_s = quo_r << 1;
            e1_s = exp_r - 10'sd1;
        end
        x_s    = qn_s[QBITS-1 -: 26];
        st_s   = (|qn_s[QBITS-27:0]) | (|rem_r);
        sh_s   = 10'sd1 - e1_s;
        sh5_s  = (sh_s > 10'sd31) ? 5'd31 : sh_s[4:0];
        wide_s = {x_s, 32'd0} >> sh5_s;
        if (e1_s <= 10'sd0) begin
            x2_s  = wide_s[57:32];
            st2_s = st_s | (|wide_s[31:0]);
            e2_s  = 10'sd0;
        end else begin
            x2_s  = x_s;
            st2_s = st_s;
            e2_s  = e1_s;
        end
        // x2_s = {24-bit mantissa, guard, round}
        case (rm_r)
            2'b00:   inc_s = x2_s[1] & (x2_s[0] | st2_s | x2_s[2]);
            2'b01:   inc_s = (x2_s[1] | x2_s[0] | st2_s) & sign_r;
            2'b10:   inc_s = (x2_s[1] | x2_s[0] | st2_s) & ~sign_r;
            default: inc_s = 1'b0;
        endcase
        m25_s = {1'b0, x2_s[25:2]} + 25'(inc_s);
        if (e2_s == 10'sd0) begin
            expo_s = $signed({9'd0, m25_s[23]});
            frac_s = m25_s[22:0];
        end else if (m25_s[24]) begin
            expo_s = e2_s + 10'sd1;
            frac_s = m25_s[23:1];
        end else begin
            expo_s = e2_s;
            frac_s = m25_s[22:0];
        end
        ovf_s = (e1_s >= 10'sd255) || (expo_s >= 10'sd255);
        if (spec_r) begin
            res_s = spec_val_r;
        end else if (ovf_s) begin
            case (rm_r)
                2'b00:   res_s = {sign_r, 8'hff, 23'd0};
                2'b01:   res_s = sign_r ? {1'b1, 8'hff, 23'd0} : {1'b0, 31'h7f7f_ffff};
                2'b10:   res_s = sign_r ? {1'b1, 31'h7f7f_ffff} : {1'b0, 8'hff, 23'd0};
                default: res_s = {sign_r, 31'h7f7f_ffff};
            endcase
        end else begin
            res_s = {sign_r, expo_s[7:0], frac_s};
        end
    end

    // next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_PREP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PREP: state_nx_s = ST_DIV;
            ST_DIV: begin
                if (cnt_r == '0) begin
                    state_nx_s = ST_ROUND;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_ROUND: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            rm_r       <= 2'b00;
            cnt_r      <= '0;
            sign_r     <= 1'b0;
            exp_r      <= 10'sd0;
            mb_r       <= 24'd0;
            rem_r      <= 26'd0;
            quo_r      <= '0;
            spec_r     <= 1'b0;
            spec_dz_r  <= 1'b0;
            spec_val_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        rm_r <= rm;
                    end
                end
                ST_PREP: begin
                    sign_r     <= sign_s;
                    exp_r      <= exp_prep_s;
                    mb_r       <= mb_n_s;
                    rem_r      <= {2'b00, ma_n_s};
                    quo_r      <= '0;
                    cnt_r      <= CW'(QBITS - 1);
                    spec_r     <= spec_s;
                    spec_dz_r  <= spec_dz_s;
                    spec_val_r <= spec_val_s;
                end
                ST_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= {quo_r[QBITS-2:0], qbit_s};
                    cnt_r <= cnt_r - 1'b1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // registered outputs; s/dz update only as ready is raised
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            s_r     <= 32'd0;
            dz_r    <= 1'b0;
        end else begin
            busy_r  <= (state_nx_s != ST_IDLE);
            ready_r <= (state_r == ST_ROUND);
            if (state_r == ST_ROUND) begin
                s_r  <= res_s;
                dz_r <= spec_r & spec_dz_r;
            end
        end
    end

    assign busy  = busy_r;
    assign ready = ready_r;
    assign s     = s_r;
    assign dz    = dz_r;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed vector table, control corner cases and
// random operands against an exact rational reference model.
`timescale 1ns/1ps
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    logic [1:0]  rm;
    logic        busy, ready, dz;
    logic [31:0] s;

    int n_cmp = 0;
    int n_bad = 0;

    fdiv_seq #(.QBITS(27)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rm(rm),
        .busy(busy), .ready(ready), .s(s), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] s;
        logic        dz;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // Exact reference: quotient as a scaled integer ratio, rounded by the IEEE rules.
    function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] md);
        logic         sg, xz, yz, xi, yi, xn, yn, dst, inexact, up;
        logic [7:0]   ex, ey;
        logic [22:0]  fx, fy, nf;
        logic [255:0] mx, my, num, q, low, half, kept;
        logic [31:0]  inf_v, max_v, r;
        logic         rdz;
        int           px, py, p, msb, l, d, eb;
        sg = x[31] ^ y[31];
        ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0];
        xz = (ex == 8'd0) && (fx == 23'd0);  yz = (ey == 8'd0) && (fy == 23'd0);
        xi = (ex == 8'hff) && (fx == 23'd0); yi = (ey == 8'hff) && (fy == 23'd0);
        xn = (ex == 8'hff) && (fx != 23'd0); yn = (ey == 8'hff) && (fy != 23'd0);
        inf_v = {sg, 8'hff, 23'd0};
        max_v = {sg, 8'hfe, 23'h7fffff};
        rdz = 1'b0;
        r = 32'd0;
        if (xn || yn) begin
            nf = (xn && (!yn || fx >= fy)) ? fx : fy;
            r = {sg, 8'hff, 1'b1, nf[21:0]};
        end else if ((xi && yi) || (xz && yz)) begin
            r = {sg, 31'h7fc00000};
        end else if (xi) begin
            r = inf_v;
        end else if (yz) begin
            r = inf_v;
            rdz = 1'b1;
        end else if (xz || yi) begin
            r = {sg, 31'd0};
        end else begin
            mx = (ex == 8'd0) ? 256'(fx) : 256'({1'b1, fx});
            my = (ey == 8'd0) ? 256'(fy) : 256'({1'b1, fy});
            px = (ex == 8'd0) ? -149 : int'(ex) - 150;
            py = (ey == 8'd0) ? -149 : int'(ey) - 150;
            num = mx << 60;
            q   = num / my;
            dst = (num % my) != 256'd0;
            p   = px - py - 60;
            msb = 0;
            for (int i = 0; i < 256; i++) if (q[i]) msb = i;
            l = msb + p - 23;
            if (l < -149) l = -149;
            d = l - p;
            kept = q >> d;
            low  = q & ((256'd1 << d) - 256'd1);
            half = 256'd1 << (d - 1);
            inexact = (low != 256'd0) || dst;
            case (md)
                2'b00:   up = (low > half) || ((low == half) && (dst || kept[0]));
                2'b01:   up = inexact && sg;
                2'b10:   up = inexact && !sg;
                default: up = 1'b0;
            endcase
            kept = kept + 256'(up);
            if (kept == (256'd1 << 24)) begin
                kept = kept >> 1;
                l = l + 1;
            end
            eb = (kept >= (256'd1 << 23)) ? l + 150 : 0;
            if (eb >= 255) begin
                case (md)
                    2'b00:   r = inf_v;
                    2'b01:   r = sg ? inf_v : max_v;
                    2'b10:   r = sg ? max_v : inf_v;
                    default: r = max_v;
                endcase
            end else begin
                r = {sg, eb[7:0], kept[22:0]};
            end
        end
        return {rdz, r};
    endfunction

    function automatic logic [31:0] rand_fp();
        int          k;
        logic        sg;
        logic [22:0] f;
        logic [7:0]  e;
        k  = $urandom_range(0, 15);
        sg = 1'($urandom());
        f  = 23'($urandom());
        case (k)
            0:       return {sg, 31'd0};
            1:       return {sg, 8'hff, 23'd0};
            2:       return {sg, 8'hff, f | 23'd1};
            3, 4:    return {sg, 8'd0, f | 23'd1};
            5:       e = 8'($urandom_range(1, 20));
            6:       e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {sg, e, f};
    endfunction

    // Bounded wait for ready; lat stays 0 on timeout.
    task automatic wait_ready(output int lat);
        lat = 0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (ready) lat = i;
        end
    endtask

    task automatic do_op(input logic [31:0] ai, input logic [31:0] bi, input logic [1:0] ri,
                         output logic [31:0] so, output logic dzo, output int lat);
        @(negedge clk);
        a = ai; b = bi; rm = ri; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after start", 32'(busy), 32'd1);
        a = $urandom(); b = $urandom(); rm = 2'($urandom());
        wait_ready(lat);
        so = s; dzo = dz;
    endtask

    initial begin
        logic [31:0] got_s, s_first;
        logic        got_dz;
        logic [32:0] exp_r;
        logic [31:0] ra, rb;
        logic [1:0]  rr;
        int          lat, pulses, first;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 2'b00, 32'h3F000000, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAA, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, 1'b1};
        vecs[5]  = '{32'h00000000, 32'h00000000, 2'b00, 32'h7FC00000, 1'b0};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 2'b00, 32'h7FC00000, 1'b0};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00001, 1'b0};
        vecs[8]  = '{32'h7F7FFFFF, 32'h00800000, 2'b00, 32'h7F800000, 1'b0};
        vecs[9]  = '{32'h7F7FFFFF, 32'h00800000, 2'b11, 32'h7F7FFFFF, 1'b0};
        vecs[10] = '{32'h00800000, 32'h40000000, 2'b00, 32'h00400000, 1'b0};
        vecs[11] = '{32'h00000001, 32'h3F800000, 2'b00, 32'h00000001, 1'b0};
        vecs[12] = '{32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 1'b0};
        vecs[13] = '{32'hBF800000, 32'h40400000, 2'b01, 32'hBEAAAAAB, 1'b0};
        vecs[14] = '{32'h7F7FFFFF, 32'h00800000, 2'b01, 32'h7F7FFFFF, 1'b0};
        vecs[15] = '{32'h7F7FFFFF, 32'h00800000, 2'b10, 32'h7F800000, 1'b0};
        vecs[16] = '{32'hBF800000, 32'h00000000, 2'b00, 32'hFF800000, 1'b1};
        vecs[17] = '{32'h3F800000, 32'h7F800000, 2'b00, 32'h00000000, 1'b0};
        vecs[18] = '{32'hC0000000, 32'h7F800000, 2'b00, 32'h80000000, 1'b0};
        vecs[19] = '{32'h7F800000, 32'hC0000000, 2'b00, 32'hFF800000, 1'b0};

        rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; rm = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset ready", 32'(ready), 32'd0);
        check("reset s", s, 32'd0);
        check("reset dz", 32'(dz), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].rm, got_s, got_dz, lat);
            check($sformatf("vec%0d s", i), got_s, vecs[i].s);
            check($sformatf("vec%0d dz", i), 32'(got_dz), 32'(vecs[i].dz));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd29);
            check($sformatf("vec%0d busy in ready cycle", i), 32'(busy), 32'd0);
        end

        // start while busy is ignored: exactly one ready, for the first operands
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; rm = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; first = 0; s_first = 32'd0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    s_first = s;
                end
            end
            start = (i == 5);
            if (i == 5) begin
                a = 32'h40000000; b = 32'h3F800000;
            end
        end
        check("busy-start pulses", 32'(pulses), 32'd1);
        check("busy-start latency", 32'(first), 32'd29);
        check("busy-start s", s_first, 32'h3EAAAAAB);

        // start in the ready cycle is accepted
        do_op(32'h40400000, 32'h40000000, 2'b00, got_s, got_dz, lat);
        check("b2b first s", got_s, 32'h3FC00000);
        a = 32'hC0800000; b = 32'h40000000; rm = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(lat);
        check("b2b second latency", 32'(lat), 32'd29);
        check("b2b second s", s, 32'hC0000000);

        // reset in the middle of an operation
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; rm = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-op reset busy", 32'(busy), 32'd0);
        check("mid-op reset ready", 32'(ready), 32'd0);
        check("mid-op reset s", s, 32'd0);
        check("mid-op reset dz", 32'(dz), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        check("mid-op reset no ready", 32'(pulses), 32'd0);

        // random operands against the reference model
        for (int i = 0; i < 300; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            rr = 2'($urandom());
            exp_r = ref_div(ra, rb, rr);
            do_op(ra, rb, rr, got_s, got_dz, lat);
            check($sformatf("rand%0d %08h/%08h rm%0d s", i, ra, rb, rr), got_s, exp_r[31:0]);
            check($sformatf("rand%0d dz", i), 32'(got_dz), 32'(exp_r[32]));
            check($sformatf("rand%0d latency", i), 32'(lat), 32'd29);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
